control_maxpool_layer1: RTL and testbench

- Stage directly downstream of the layer-1 convolution control/datapath. Consumes its valid-qualified stream of bias-added conv results, in raster order.
- Performs 2x2, stride-2 max pooling and emits one pooled value per 2x2 window with pooled-map coordinates.
- Holds the tracking counters, a half-row line buffer and the output valid, so the next layer receives a clean pooled stream.

---
 rtl/control_maxpool_layer1_if.sv | 36 +++
 rtl/control_maxpool_layer1.sv | 137 +++++++++++++
 tb/tb_control_maxpool_layer1.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/control_maxpool_layer1_if.sv
// Stream interface between the layer-1 convolution stage and the layer-1
// max-pooling stage: a valid-qualified pixel stream going in and a
// valid-qualified pooled stream (with pooled-map coordinates) coming out.
interface control_maxpool_layer1_if #(
    parameter int DATA_W = 16
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] data_in;
    logic                     valid_out;
    logic signed [DATA_W-1:0] data_out;
    logic        [31:0]       out_col;
    logic        [31:0]       out_row;
    logic                     frame_done;

    // Producer side: drives conv pixels, observes pooled results.
    modport master (
        output valid_in,
        output data_in,
        input  valid_out,
        input  data_out,
        input  out_col,
        input  out_row,
        input  frame_done
    );

    // Pooling stage side: consumes conv pixels, drives pooled results.
    modport slave (
        input  valid_in,
        input  data_in,
        output valid_out,
        output data_out,
        output out_col,
        output out_row,
        output frame_done
    );
endinterface

// File: rtl/control_maxpool_layer1.sv
// Layer-1 2x2 / stride-2 max pooling over a raster-ordered conv stream.
// Even columns are parked in a hold register, odd columns form the
// horizontal max of the pair. Even rows store that pair max in a half-row
// line buffer; odd rows combine it with the stored value and emit one pooled
// result per window, registered, one cycle after the window's last pixel.
module control_maxpool_layer1 #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    control_maxpool_layer1_if.slave  bus
);

    localparam int HALF_W = WIDTH / 2;
    localparam int COL_W  = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W  = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    // Odd or degenerate frame sizes cannot be tiled by 2x2 windows.
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_badWidth
        $error("control_maxpool_layer1: WIDTH must be even and >= 2");
    end
    if ((HEIGHT < 2) || ((HEIGHT % 2) != 0)) begin : g_badHeight
        $error("control_maxpool_layer1: HEIGHT must be even and >= 2");
    end

    logic        [COL_W-1:0]  col_q, col_d;
    logic        [ROW_W-1:0]  row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] dataOut_q, dataOut_d;
    logic        [31:0]       outCol_q, outCol_d;
    logic        [31:0]       outRow_q, outRow_d;
    logic                     validOut_q, validOut_d;
    logic                     frameDone_q, frameDone_d;

    logic signed [DATA_W-1:0] lineBuf_q [HALF_W];

    logic        [IDX_W-1:0]  lbIdx;
    logic signed [DATA_W-1:0] lineRd;
    logic signed [DATA_W-1:0] hMax;
    logic signed [DATA_W-1:0] vMax;
    logic                     colOdd;
    logic                     rowOdd;
    logic                     colLast;
    logic                     rowLast;
    logic                     lbWrite;

    assign colOdd  = col_q[0];
    assign rowOdd  = row_q[0];
    assign colLast = (col_q == COL_LAST);
    assign rowLast = (row_q == ROW_LAST);

    // Each horizontal pixel pair owns one line-buffer slot.
    assign lbIdx   = IDX_W'(col_q >> 1);
    assign lineRd  = lineBuf_q[lbIdx];

    // Pair max of the parked even pixel and the current odd pixel, then the
    // window max against the pair stored from the row above.
    assign hMax    = (bus.data_in > hold_q) ? bus.data_in : hold_q;
    assign vMax    = (lineRd > hMax) ? lineRd : hMax;

    // The top row of every window deposits its pair max for the row below.
    assign lbWrite = !rst && bus.valid_in && colOdd && !rowOdd;

    // Next-state logic: everything freezes unless a pixel is accepted.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        dataOut_d   = dataOut_q;
        outCol_d    = outCol_q;
        outRow_d    = outRow_q;
        validOut_d  = 1'b0;
        frameDone_d = 1'b0;

        if (bus.valid_in) begin
            if (colLast) begin
                col_d = '0;
                row_d = rowLast ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!colOdd) begin
                hold_d = bus.data_in;
            end else if (rowOdd) begin
                validOut_d  = 1'b1;
                dataOut_d   = vMax;
                outCol_d    = 32'(col_q >> 1);
                outRow_d    = 32'(row_q >> 1);
                frameDone_d = colLast && rowLast;
            end
        end
    end

    // Tracking counters, hold register and registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            dataOut_q   <= '0;
            outCol_q    <= '0;
            outRow_q    <= '0;
            validOut_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            dataOut_q   <= dataOut_d;
            outCol_q    <= outCol_d;
            outRow_q    <= outRow_d;
            validOut_q  <= validOut_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Line buffer: no reset, every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (lbWrite) begin
            lineBuf_q[lbIdx] <= hMax;
        end
    end

    assign bus.valid_out  = validOut_q;
    assign bus.data_out   = dataOut_q;
    assign bus.out_col    = outCol_q;
    assign bus.out_row    = outRow_q;
    assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_control_maxpool_layer1.sv
// Self-checking bench for control_maxpool_layer1: a 4x4 instance and a 6x2
// instance driven with directed and randomized frames (with random input
// gaps and a mid-frame reset), checked every cycle against a frame-array
// reference model of 2x2 max pooling.
module tb_control_maxpool_layer1;

    localparam int DATA_W = 16;
    localparam int WA = 4;
    localparam int HA = 4;
    localparam int WB = 6;
    localparam int HB = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_maxpool_layer1_if #(.DATA_W(DATA_W)) busA ();
    control_maxpool_layer1_if #(.DATA_W(DATA_W)) busB ();

    control_maxpool_layer1 #(.WIDTH(WA), .HEIGHT(HA), .DATA_W(DATA_W)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    control_maxpool_layer1 #(.WIDTH(WB), .HEIGHT(HB), .DATA_W(DATA_W)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state: pixels of the current frame in raster order.
    int frameMem [2][16];
    int pixIdx   [2];
    int lastData [2];
    int lastCol  [2];
    int lastRow  [2];

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int dimW(input int sel);
        return (sel == 0) ? WA : WB;
    endfunction

    function automatic int dimH(input int sel);
        return (sel == 0) ? HA : HB;
    endfunction

    // Read one DUT's output stream.
    task automatic sampleOutputs(input int sel, output int v, output int d,
                                 output int c, output int r, output int fd);
        if (sel == 0) begin
            v = int'(busA.valid_out); d = busA.data_out;
            c = int'(busA.out_col);   r = int'(busA.out_row);
            fd = int'(busA.frame_done);
        end else begin
            v = int'(busB.valid_out); d = busB.data_out;
            c = int'(busB.out_col);   r = int'(busB.out_row);
            fd = int'(busB.frame_done);
        end
    endtask

    // Compare all five outputs of one DUT with expected values.
    task automatic checkAll(input int sel, input int expV, input int expFd);
        int v, d, c, r, fd;
        string p;
        p = (sel == 0) ? "A." : "B.";
        sampleOutputs(sel, v, d, c, r, fd);
        checkOutput({p, "valid_out"}, v, expV);
        checkOutput({p, "frame_done"}, fd, expFd);
        checkOutput({p, "data_out"}, d, lastData[sel]);
        checkOutput({p, "out_col"}, c, lastCol[sel]);
        checkOutput({p, "out_row"}, r, lastRow[sel]);
    endtask

    // One clock cycle on DUT 'sel' (the other DUT idles), then check it.
    task automatic applyStimulus(input int sel, input bit v, input int d);
        int expV, expFd, k, x, y, w, h;
        busA.valid_in = (sel == 0) && v;
        busA.data_in  = 16'(d);
        busB.valid_in = (sel == 1) && v;
        busB.data_in  = 16'(d);
        @(posedge clk);
        #1;
        busA.valid_in = 1'b0;
        busB.valid_in = 1'b0;
        expV  = 0;
        expFd = 0;
        if (v) begin
            w = dimW(sel);
            h = dimH(sel);
            k = pixIdx[sel];
            frameMem[sel][k] = d;
            x = k % w;
            y = k / w;
            if ((x % 2 == 1) && (y % 2 == 1)) begin
                expV = 1;
                lastData[sel] = maxOf(maxOf(frameMem[sel][k], frameMem[sel][k-1]),
                                      maxOf(frameMem[sel][k-w], frameMem[sel][k-w-1]));
                lastCol[sel] = x / 2;
                lastRow[sel] = y / 2;
                expFd = (k == w * h - 1) ? 1 : 0;
            end
            pixIdx[sel] = (k + 1) % (w * h);
        end
        checkAll(sel, expV, expFd);
    endtask

    // Hold reset for some cycles; both DUTs must show cleared outputs.
    task automatic applyReset(input int cycles);
        rst = 1'b1;
        busA.valid_in = 1'b0; busA.data_in = '0;
        busB.valid_in = 1'b0; busB.data_in = '0;
        for (int s = 0; s < 2; s++) begin
            pixIdx[s] = 0; lastData[s] = 0; lastCol[s] = 0; lastRow[s] = 0;
        end
        repeat (cycles) begin
            @(posedge clk);
            #1;
            checkAll(0, 0, 0);
            checkAll(1, 0, 0);
        end
        rst = 1'b0;
    endtask

    // kind 0: base+k, kind 1: -(k+1), kind 2: random signed values.
    task automatic sendFrame(input int sel, input int kind, input int base, input int maxGap);
        int n, d;
        n = dimW(sel) * dimH(sel);
        for (int k = 0; k < n; k++) begin
            case (kind)
                0:       d = base + k;
                1:       d = -(k + 1);
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            applyStimulus(sel, 1'b1, d);
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) applyStimulus(sel, 1'b0, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        applyReset(2);

        sendFrame(0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1'b0, 0);
        sendFrame(0, 1, 0, 0);
        sendFrame(0, 0, 0, 5);
        sendFrame(0, 0, 0, 0);
        sendFrame(0, 0, 100, 0);

        for (int k = 0; k < 6; k++) applyStimulus(0, 1'b1, 1000 + k);
        applyReset(2);
        sendFrame(0, 0, 0, 0);

        repeat (4) sendFrame(0, 2, 0, 3);

        sendFrame(1, 0, 0, 0);
        sendFrame(1, 0, 0, 2);
        repeat (3) sendFrame(1, 2, 0, 1);
        repeat (2) applyStimulus(1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
